// File: rtl/dp_pkg.sv
// Shared definitions for the multi-cycle datapath: opcodes, instruction field
// positions, FSM states and ALU operation codes.
package dp_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_SLL  = 4'd4;
   localparam logic [3:0] OP_ADDI = 4'd5;
   localparam logic [3:0] OP_LW   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;
   localparam logic [3:0] OP_J    = 4'd9;
   localparam logic [3:0] OP_HALT = 4'd13;
   localparam logic [3:0] OP_BEQ  = 4'd14;
   localparam logic [3:0] OP_BNE  = 4'd15;

   // low bit of each field in the 16-bit instruction word
   localparam int OP_LSB  = 12;
   localparam int RD_LSB  = 9;
   localparam int RS1_LSB = 6;
   localparam int RS2_LSB = 3;
   localparam int SH_LSB  = 0;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLL
   } alu_op_t;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU: add/sub/and/or/shift-left plus an operand equality flag
// used by the branch instructions.
module dp_alu
   import dp_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  alu_op_t             op,
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   input  logic [2:0]          shamt,
   output logic [DATA_W-1:0]   y,
   output logic                eq
);

   always_comb begin
      y = a + b;
      case (op)
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_SLL: y = a << shamt;
         default: y = a + b;
      endcase
   end

   assign eq = (a == b);

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle 16-bit-ISA processor: FETCH/DECODE/EXEC/MEM/WB control FSM,
// 8-entry register file, instruction and data memories, program-load port.
module multicycle_datapath
   import dp_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int IMEM_DEPTH = 16,
   parameter int DMEM_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          run,
   input  logic                          prog_we,
   input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
   input  logic [15:0]                   prog_data,
   input  logic [2:0]                    dbg_sel,
   output logic [DATA_W-1:0]             dbg_data,
   output logic [$clog2(IMEM_DEPTH)-1:0] pc,
   output logic                          halted,
   output logic                          busy
);

   localparam int PC_W = $clog2(IMEM_DEPTH);
   localparam int DA_W = $clog2(DMEM_DEPTH);

   state_t            state, state_n;
   logic [15:0]       ir;
   logic [DATA_W-1:0] a_r, b_r, aluout, mdr;
   logic              run_q;

   logic [DATA_W-1:0] rf   [8];
   logic [15:0]       imem [IMEM_DEPTH];
   logic [DATA_W-1:0] dmem [DMEM_DEPTH];

   logic [3:0]        op;
   logic [2:0]        rd, rs1, rs2, shamt, b_idx;
   logic [DATA_W-1:0] imm6_x, alu_b, alu_y;
   logic [PC_W-1:0]   pc_inc, pc_br, pc_j;
   logic              alu_eq, use_imm, is_alu, run_rise;
   alu_op_t           alu_op;

   assign op    = ir[OP_LSB  +: 4];
   assign rd    = ir[RD_LSB  +: 3];
   assign rs1   = ir[RS1_LSB +: 3];
   assign rs2   = ir[RS2_LSB +: 3];
   assign shamt = ir[SH_LSB  +: 3];

   // size casts of signed operands sign-extend (or wrap) to the target width
   assign imm6_x = DATA_W'($signed(ir[5:0]));
   assign pc_inc = pc + PC_W'(1);
   assign pc_br  = pc_inc + PC_W'($signed(ir[5:0]));
   assign pc_j   = pc_inc + PC_W'($signed(ir[8:0]));

   assign use_imm  = (op == OP_ADDI) || (op == OP_LW) || (op == OP_SW);
   assign is_alu   = (op <= OP_SLL) || (op == OP_ADDI);
   assign b_idx    = ((op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE)) ? rd : rs2;
   assign alu_b    = use_imm ? imm6_x : b_r;
   assign run_rise = run && !run_q;

   always_comb begin
      case (op)
         OP_SUB:  alu_op = ALU_SUB;
         OP_AND:  alu_op = ALU_AND;
         OP_OR:   alu_op = ALU_OR;
         OP_SLL:  alu_op = ALU_SLL;
         default: alu_op = ALU_ADD;
      endcase
   end

   dp_alu #(.DATA_W(DATA_W)) u_alu (
      .op    (alu_op),
      .a     (a_r),
      .b     (alu_b),
      .shamt (shamt),
      .y     (alu_y),
      .eq    (alu_eq)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_n;
   end

   // an instruction finishing with run low parks in IDLE instead of fetching
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   if (run) state_n = S_FETCH;
         S_FETCH:  state_n = S_DECODE;
         S_DECODE: state_n = S_EXEC;
         S_EXEC: begin
            if (op == OP_HALT)                      state_n = S_HALT;
            else if (op == OP_LW || op == OP_SW)    state_n = S_MEM;
            else if (is_alu)                        state_n = S_WB;
            else                                    state_n = run ? S_FETCH : S_IDLE;
         end
         S_MEM: begin
            if (op == OP_LW) state_n = S_WB;
            else             state_n = run ? S_FETCH : S_IDLE;
         end
         S_WB:     state_n = run ? S_FETCH : S_IDLE;
         S_HALT:   if (run_rise) state_n = S_FETCH;
         default:  state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc     <= '0;
         ir     <= '0;
         a_r    <= '0;
         b_r    <= '0;
         aluout <= '0;
         mdr    <= '0;
         run_q  <= 1'b0;
         for (int i = 0; i < 8; i++) rf[i] <= '0;
      end else begin
         run_q <= run;
         case (state)
            S_FETCH:  ir <= imem[pc];
            S_DECODE: begin
               a_r <= rf[rs1];
               b_r <= rf[b_idx];
            end
            S_EXEC: begin
               aluout <= alu_y;
               if (op == OP_J)                          pc <= pc_j;
               else if (op == OP_BEQ)                   pc <= alu_eq ? pc_br : pc_inc;
               else if (op == OP_BNE)                   pc <= alu_eq ? pc_inc : pc_br;
               else if (!is_alu && op != OP_HALT &&
                        op != OP_LW && op != OP_SW)     pc <= pc_inc;
            end
            S_MEM: begin
               if (op == OP_LW) mdr <= dmem[aluout[DA_W-1:0]];
               else             pc  <= pc_inc;
            end
            S_WB: begin
               if (rd != 3'd0) rf[rd] <= (op == OP_LW) ? mdr : aluout;
               pc <= pc_inc;
            end
            S_HALT:   if (run_rise) pc <= '0;
            default:  ;
         endcase
      end
   end

   // memories carry no reset; reset only suppresses writes
   always_ff @(posedge clk) begin
      if (!reset && state == S_MEM && op == OP_SW)
         dmem[aluout[DA_W-1:0]] <= b_r;
   end

   always_ff @(posedge clk) begin
      if (!reset && prog_we && (state == S_IDLE || state == S_HALT))
         imem[prog_addr] <= prog_data;
   end

   assign dbg_data = rf[dbg_sel];
   assign halted   = (state == S_HALT);
   assign busy     = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC) ||
                     (state == S_MEM)   || (state == S_WB);

endmodule

// File: doc/multicycle_datapath.md
# multicycle_datapath

Parametrised multi-cycle successor to the team's single-cycle 16-bit processor datapath. It executes the same 16-bit instruction format through an explicit FETCH/DECODE/EXEC/MEM/WB state machine, so each register-file and memory access has a defined cycle. It adds configurable data width and memory depths, a program-load port, run/halt control and a debug register read port. It sits at the top of the processor, below the testbench/SoC wrapper.

## Interface
- DATA_W, 16, register/ALU/data-memory word width (>= 16)
- IMEM_DEPTH, 16, instruction words, power of 2
- DMEM_DEPTH, 8, data words, power of 2
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- run  in  1  level; leaving IDLE requires run=1
- prog_we  in  1  instruction-memory write strobe, honoured only in IDLE or HALT
- prog_addr  in  $clog2(IMEM_DEPTH)  instruction-memory write address
- prog_data  in  16  instruction word
- dbg_sel  in  3  register index for debug read
- dbg_data  out  DATA_W  combinational RF[dbg_sel]
- pc  out  $clog2(IMEM_DEPTH)  current program counter
- halted  out  1  high in HALT state
- busy  out  1  high in FETCH..WB

## Operation
- Instruction fields: op[15:12], rd[11:9], rs1[8:6], rs2[5:3], shamt[2:0], imm6[5:0], imm9[8:0]. Immediates are sign-extended to DATA_W.
- Opcodes:
  - 0 ADD: rd=rs1+rs2
  - 1 SUB: rd=rs1-rs2
  - 2 AND
  - 3 OR
  - 4 SLL: rd=rs1<<shamt
  - 5 ADDI: rd=rs1+imm6
  - 7 LW: rd=DMEM[rs1+imm6]
  - 8 SW: DMEM[rs1+imm6]=rd
  - 9 J: pc=pc+1+imm9
  - 14 BEQ: if rs1==rd then pc=pc+1+imm6
  - 15 BNE: if rs1!=rd then pc=pc+1+imm6
  - 13 HALT
  - All other opcodes are NOP.
- Arithmetic wraps modulo 2^DATA_W; no flags.
- Data address is the low $clog2(DMEM_DEPTH) bits of the sum.
- pc wraps modulo IMEM_DEPTH.
- RF has 8 entries. RF[0] reads zero and writes to it are discarded.
- States:
  - IDLE: waits for run=1, then goes to FETCH.
  - FETCH: IR<=IMEM[pc] → DECODE.
  - DECODE: A<=RF[rs1], B<=RF[rs2 or rd] → EXEC.
  - EXEC: ALU result/address into ALUOUT. Branch/J/NOP update pc and go to FETCH. HALT goes to HALT. LW/SW go to MEM. All others go to WB.
  - MEM: LW sets MDR<=DMEM[addr] → WB; SW writes DMEM, pc+=1, → FETCH.
  - WB: writes RF[rd], pc+=1, → FETCH.
  - HALT: stays until reset, or until run goes 0→1, which sets pc<=0 and goes to FETCH.
- If run drops mid-instruction, the current instruction completes, then the block returns to IDLE instead of FETCH.
- prog_we outside IDLE/HALT is ignored, so IMEM is unchanged.
- Reset contents:
  - pc=0, state=IDLE, IR=0, A/B/ALUOUT/MDR=0, all RF entries=0.
  - DMEM and IMEM are not reset; they are loaded via prog port or initial contents.

## Timing
- Reset values: halted=0, busy=0, pc=0, dbg_data=0.
- Cycles per instruction:
  - R-type/ADDI: 4 (F,D,E,W)
  - LW: 5 (F,D,E,M,W)
  - SW: 4 (F,D,E,M)
  - J/BEQ/BNE/NOP: 3
  - HALT: 3, with halted asserted the cycle after EXEC.
- RF writes become visible on dbg_data the cycle after WB.
- A DMEM write in MEM is readable by an LW issued afterwards; there is no hazard because execution is strictly sequential.
- First FETCH occurs the cycle after run is sampled high in IDLE.
- Reset asserted in any state wins over all other inputs. The in-flight instruction is discarded: no RF or DMEM write occurs in that cycle.
- If prog_we and run=1 arrive in the same IDLE cycle, the write happens and the FETCH next cycle sees the new word.

## Structure
- Package dp_pkg holds:
  - opcode localparams (OP_ADD … OP_BNE)
  - state enum (S_IDLE … S_HALT)
  - field bit positions.
- One sub-module, dp_alu (combinational, parametrised by DATA_W), implementing ADD/SUB/AND/OR/SLL and the equality compare.
- Control FSM, RF, IMEM and DMEM stay in the top module.

## Test plan
- Reset mid-EXEC of ADD r1,r2,r3 (r2=2, r3=1) → r1 stays 0, pc=0, busy=0 next cycle.
- Program load, then run: ADDI r2,r0,5; ADDI r3,r0,7; ADD r1,r2,r3; HALT → r1=12, halted=1 at cycle 15 after run.
- SW r1 to [r0+3], then LW r4 from [r0+3] with r1=0x1B → dbg_sel=4 reads 0x001B. LW costs 5 cycles.
- Branches: BEQ r5,r6,+2 with r5=r6=1 → pc advances by 3. BNE with equal operands → pc advances by 1.
- Wrap-around:
  - J with imm9=-1 at pc=0 → pc=0 (self-loop; check for 3 iterations).
  - pc=15 falling through to the next instruction → pc=0.
  - DATA_W=16: 0xFFFF+1 → 0.
- Write-protect and restart:
  - prog_we while busy → IMEM unchanged.
  - From HALT, run 0→1 → restart at pc=0.
  - ADDI r0,r0,9 → r0 reads 0.
